// File: rtl/linear_m_inv_serial_if.sv
// Nibble-stream bundle for linear_m_inv_serial: one input stream and one output stream,
// each nibble carrying SHARES share lanes side by side.
interface linear_m_inv_serial_if #(
    parameter int SHARES = 3
);
    logic                in_valid;
    logic                in_ready;
    logic [4*SHARES-1:0] in_nibble;
    logic                out_valid;
    logic                out_ready;
    logic [4*SHARES-1:0] out_nibble;
    logic                out_last;

    modport slave (
        input  in_valid, in_nibble, out_ready,
        output in_ready, out_valid, out_nibble, out_last
    );

    modport master (
        output in_valid, in_nibble, out_ready,
        input  in_ready, out_valid, out_nibble, out_last
    );
endinterface

// File: rtl/linear_m_inv_serial.sv
// Nibble-serial inverse PRINCE M' nibble permutation (inverse ShiftRows), applied share-wise.
// Two ping-pong banks: one fills in arrival order while the other drains in permuted order.
module linear_m_inv_serial #(
    parameter int SHARES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    linear_m_inv_serial_if.slave  io_strm
);
    localparam int W = 4 * SHARES;

    typedef enum logic {
        BANK_FREE = 1'b0,
        BANK_FULL = 1'b1
    } bank_st_t;

    bank_st_t     r_bank_st     [2];
    bank_st_t     w_bank_st_nxt [2];
    logic [W-1:0] r_mem         [2][16];
    logic [3:0]   r_wcnt;
    logic [3:0]   r_rcnt;
    logic         r_wb;
    logic         r_rb;

    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_wr_fire;
    logic         w_rd_fire;
    logic         w_fill_done;
    logic         w_drain_done;
    logic [3:0]   w_wslot;
    logic [3:0]   w_rslot;
    logic [3:0]   w_rcnt_x2;

    // Handshake qualifiers come from flag registers only, never from the partner's valid/ready.
    assign w_in_ready   = (r_bank_st[r_wb] == BANK_FREE);
    assign w_out_valid  = (r_bank_st[r_rb] == BANK_FULL);
    assign w_wr_fire    = io_strm.in_valid & w_in_ready;
    assign w_rd_fire    = w_out_valid & io_strm.out_ready;
    assign w_fill_done  = w_wr_fire & (r_wcnt == 4'd15);
    assign w_drain_done = w_rd_fire & (r_rcnt == 4'd15);

    // MSB-first arrival lands in slot 15-wcnt; the k-th output reads slot (15+3k) mod 16.
    assign w_wslot   = ~r_wcnt;
    assign w_rcnt_x2 = {r_rcnt[2:0], 1'b0};
    assign w_rslot   = 4'd15 + w_rcnt_x2 + r_rcnt;

    // NOTE: every variable assigned here gets its default first, so no path can infer a latch.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_bank_st_nxt[b] = r_bank_st[b];
            if (w_fill_done && (r_wb == 1'(b))) begin
                w_bank_st_nxt[b] = BANK_FULL;
            end
            if (w_drain_done && (r_rb == 1'(b))) begin
                w_bank_st_nxt[b] = BANK_FREE;
            end
        end
    end

    // NOTE: clocked state is written with non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank_st[0] <= BANK_FREE;
            r_bank_st[1] <= BANK_FREE;
            r_wcnt       <= 4'd0;
            r_rcnt       <= 4'd0;
            r_wb         <= 1'b0;
            r_rb         <= 1'b0;
        end else begin
            r_bank_st[0] <= w_bank_st_nxt[0];
            r_bank_st[1] <= w_bank_st_nxt[1];
            if (w_wr_fire) begin
                r_wcnt <= r_wcnt + 4'd1;
                if (w_fill_done) begin
                    r_wb <= ~r_wb;
                end
            end
            if (w_rd_fire) begin
                r_rcnt <= r_rcnt + 4'd1;
                if (w_drain_done) begin
                    r_rb <= ~r_rb;
                end
            end
        end
    end

    // NOTE: the banks are cleared by reset on purpose, so shares of an aborted state can never reappear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < 16; s++) begin
                    r_mem[b][s] <= '0;
                end
            end
        end else if (w_wr_fire) begin
            r_mem[r_wb][w_wslot] <= io_strm.in_nibble;
        end
    end

    assign io_strm.in_ready   = w_in_ready;
    assign io_strm.out_valid  = w_out_valid;
    assign io_strm.out_nibble = w_out_valid ? r_mem[r_rb][w_rslot] : '0;
    assign io_strm.out_last   = w_out_valid & (r_rcnt == 4'd15);

endmodule

// File: tb/tb_linear_m_inv_serial.sv
// Self-checking bench for linear_m_inv_serial: directed vectors, reset aborts,
// full-rate inverse-of-forward recovery and randomly stalled streaming.
module tb_linear_m_inv_serial;
    localparam int SHARES = 3;
    localparam int W      = 4 * SHARES;

    typedef logic [SHARES-1:0][63:0] st_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    linear_m_inv_serial_if #(.SHARES(SHARES)) bus ();

    linear_m_inv_serial #(.SHARES(SHARES)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_strm (bus)
    );

    int  n_checks = 0;
    int  n_fail   = 0;
    st_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inverse permutation: k-th output nibble (MSB first) is input nibble (15+3k) mod 16.
    function automatic logic [63:0] inv_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 16; k++) y[63-4*k -: 4] = x[4*((15+3*k)%16) +: 4];
        return y;
    endfunction

    // Forward M' permutation (what linear_m would produce), undone by this block.
    function automatic logic [63:0] fwd_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 16; k++) y[4*((15+3*k)%16) +: 4] = x[63-4*k -: 4];
        return y;
    endfunction

    task automatic set_nib(input st_t st, input int j);
        for (int l = 0; l < SHARES; l++) bus.in_nibble[4*l +: 4] = st[l][63-4*j -: 4];
    endtask

    function automatic st_t put_out(input st_t acc, input int k, input logic [W-1:0] nib);
        st_t r;
        r = acc;
        for (int l = 0; l < SHARES; l++) r[l][63-4*k -: 4] = nib[4*l +: 4];
        return r;
    endfunction

    // Fill one state with out_ready low; caller is at a negedge.
    task automatic fill_one(input st_t st);
        bus.out_ready = 1'b0;
        for (int j = 0; j < 16; j++) begin
            set_nib(st, j);
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain_one(output st_t got, output logic [15:0] lastm);
        got   = '0;
        lastm = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            got      = put_out(got, k, bus.out_nibble);
            lastm[k] = bus.out_last;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic drive_states(input int n, input int mode, input int pv);
        for (int s = 0; s < n; s++) begin
            st_t x;
            st_t st;
            st_t e;
            int  guard;
            for (int l = 0; l < SHARES; l++) begin
                x[l] = {$urandom(), $urandom()};
                if (mode == 1) begin
                    st[l] = fwd_perm(x[l]);
                    e[l]  = x[l];
                end else begin
                    st[l] = x[l];
                    e[l]  = inv_perm(x[l]);
                end
            end
            exp_q.push_back(e);
            guard = 0;
            for (int j = 0; j < 16; ) begin
                @(negedge clk);
                guard++;
                bus.in_valid = ($urandom_range(99) < pv);
                set_nib(st, j);
                if (bus.in_valid && bus.in_ready) j++;
                if (guard > 4000) begin
                    check("drv_timeout", 1'b1, 1'b0);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic collect_states(input int n, input int pr, input int max_cyc,
                                  input string tag, output int cyc);
        logic         held;
        logic [W-1:0] held_nib;
        logic         held_last;
        cyc  = 0;
        held = 1'b0;
        held_nib  = '0;
        held_last = 1'b0;
        for (int s = 0; s < n; s++) begin
            st_t         got;
            st_t         e;
            logic [15:0] lastm;
            got   = '0;
            lastm = '0;
            for (int k = 0; k < 16; ) begin
                @(negedge clk);
                cyc++;
                if (held) check({tag, "_hold"}, {bus.out_valid, bus.out_last, bus.out_nibble},
                                {1'b1, held_last, held_nib});
                bus.out_ready = ($urandom_range(99) < pr);
                held = 1'b0;
                if (bus.out_valid) begin
                    if (bus.out_ready) begin
                        got      = put_out(got, k, bus.out_nibble);
                        lastm[k] = bus.out_last;
                        k++;
                    end else begin
                        held      = 1'b1;
                        held_nib  = bus.out_nibble;
                        held_last = bus.out_last;
                    end
                end
                if (cyc > max_cyc) begin
                    check({tag, "_timeout"}, 1'b1, 1'b0);
                    return;
                end
            end
            if (exp_q.size() == 0) begin
                check({tag, "_extra"}, 1'b1, 1'b0);
                return;
            end
            e = exp_q.pop_front();
            for (int l = 0; l < SHARES; l++) check($sformatf("%s_s%0d_l%0d", tag, s, l), got[l], e[l]);
            check({tag, "_last"}, lastm, 16'h8000);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        st_t         a, b, c, d, gota, gotb, got;
        logic [31:0] vmask, lmask;
        logic [15:0] lastm;
        int          cyc;

        a[0] = 64'hFEDCBA9876543210; a[1] = 64'h0123456789ABCDEF; a[2] = 64'h0011223344556677;
        b[0] = 64'h0123456789ABCDEF; b[1] = 64'hFEDCBA9876543210; b[2] = {$urandom(), $urandom()};
        c[0] = 64'h1111111111111111; c[1] = 64'h2222222222222222; c[2] = 64'h3333333333333333;
        d[0] = 64'hFEDCBA9876543210; d[1] = {$urandom(), $urandom()}; d[2] = 64'h0123456789ABCDEF;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_nibble = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  bus.in_ready,   1'b1);
        check("rst_out_valid", bus.out_valid,  1'b0);
        check("rst_out_last",  bus.out_last,   1'b0);
        check("rst_out_nib",   bus.out_nibble, '0);

        // Two states back to back with the output blocked.
        for (int j = 0; j < 16; j++) begin
            set_nib(a, j);
            bus.in_valid = 1'b1;
            if (j == 15) check("lat_pre_valid", bus.out_valid, 1'b0);
            @(negedge clk);
        end
        check("lat_valid_rise", bus.out_valid, 1'b1);
        check("bank1_ready",    bus.in_ready,  1'b1);
        for (int j = 0; j < 16; j++) begin
            set_nib(b, j);
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("both_full_ready", bus.in_ready, 1'b0);

        gota = '0; gotb = '0; vmask = '0; lmask = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 15) check("ready_still_low", bus.in_ready, 1'b0);
            if (i == 16) check("ready_returns",   bus.in_ready, 1'b1);
            vmask[i] = bus.out_valid;
            lmask[i] = bus.out_last;
            if (i < 16) gota = put_out(gota, i, bus.out_nibble);
            else        gotb = put_out(gotb, i - 16, bus.out_nibble);
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        check("drain_valid_mask", vmask, 32'hFFFF_FFFF);
        check("drain_last_mask",  lmask, 32'h8000_8000);
        check("a_lane0", gota[0], 64'hF258BE147AD0369C);
        check("a_lane1", gota[1], 64'h0DA741EB852FC963);
        check("a_lane2", gota[2], inv_perm(a[2]));
        check("a_xor",   gota[0] ^ gota[1] ^ gota[2], inv_perm(a[0] ^ a[1] ^ a[2]));
        check("b_lane0", gotb[0], 64'h0DA741EB852FC963);
        check("b_lane1", gotb[1], 64'hF258BE147AD0369C);
        check("b_lane2", gotb[2], inv_perm(b[2]));
        check("empty_valid", bus.out_valid, 1'b0);

        // Reset after 7 input nibbles.
        for (int j = 0; j < 7; j++) begin
            set_nib(c, j);
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("prst_in_ready",  bus.in_ready,  1'b1);
        check("prst_out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_one(d);
        drain_one(got, lastm);
        check("d_lane0", got[0], 64'hF258BE147AD0369C);
        check("d_lane1", got[1], inv_perm(d[1]));
        check("d_lane2", got[2], 64'h0DA741EB852FC963);
        check("d_last",  lastm,  16'h8000);

        // Reset mid-drain.
        fill_one(c);
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("mdrn_pre_valid", bus.out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mrst_out_valid", bus.out_valid,  1'b0);
        check("mrst_out_nib",   bus.out_nibble, '0);
        check("mrst_out_last",  bus.out_last,   1'b0);
        check("mrst_in_ready",  bus.in_ready,   1'b1);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        fill_one(a);
        drain_one(got, lastm);
        check("post_lane0", got[0], 64'hF258BE147AD0369C);
        check("post_lane1", got[1], 64'h0DA741EB852FC963);
        check("post_lane2", got[2], inv_perm(a[2]));

        // Forward permutation followed by this block recovers the state at full rate.
        fork
            drive_states(1000, 1, 100);
            collect_states(1000, 100, 16 * 1000 + 64, "inv", cyc);
        join
        check("throughput", (cyc <= 16 * 1000 + 16), 1'b1);

        // Random valid/ready toggling.
        fork
            drive_states(200, 0, 60);
            collect_states(200, 60, 40000, "rnd", cyc);
        join
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
